obstacle_scheduler: RTL
=======================

// Module: obstacle_scheduler
// PURPOSE
//  Frame-rate controller for the obstacle pool. Sequences per-frame scroll, retire and spawn of
//  NUM_SLOTS obstacle slots; hands per-slot left-edge x, type and active flags to the pixel compositor.
//  Owns the game run state (IDLE/RUN/HALT) and the scroll-speed ramp.
//  Sits between the VGA timing generator (animate pulse) and the obstacle renderers.
// PARAMETERS
//  NUM_SLOTS          4     obstacle slots in pool (2..8)
//  SPAWN_X            640   x loaded into a newly spawned slot (10-bit)
//  INIT_SPEED         2     px/frame after start
//  MAX_SPEED          8     speed saturation value (4-bit)
//  SPEED_STEP_FRAMES  600   frames between speed increments
//  MIN_GAP_FRAMES     40    minimum frames between spawns
//  GAP_MASK           8'h3F random extra gap = lfsr[7:0] & GAP_MASK
// PORTS
//  i_clk        in   1            system clock
//  i_rst_n      in   1            synchronous reset, active low
//  i_animate    in   1            1-cycle pulse at end of visible frame
//  i_start      in   1            pulse: start/restart game
//  i_collide    in   1            level: dino overlaps an obstacle
//  o_active     out  NUM_SLOTS    slot k holds a live obstacle
//  o_x          out  NUM_SLOTS*10 slot k left edge at [10k+9:10k]
//  o_is_bird    out  NUM_SLOTS    slot k type: 1 = bird, 0 = cactus
//  o_speed      out  4            current scroll speed
//  o_running    out  1            high in states MOVE/SPAWN/WAIT
//  o_frame_done out  1            1-cycle pulse when frame update completes
// BEHAVIOUR
//  Reset (i_rst_n=0 on a clock edge): state=IDLE, o_active=0, o_x=0, o_is_bird=0,
//   o_speed=INIT_SPEED, o_running=0, o_frame_done=0, gap=MIN_GAP_FRAMES, speed_cnt=0,
//   lfsr=16'hACE1. Reset wins over every other input, including mid-MOVE.
//  States: IDLE, WAIT, MOVE, SPAWN, HALT.
//   IDLE : i_start -> clear slots, reload speed/gap/lfsr as at reset, -> WAIT.
//   WAIT : i_collide -> HALT (priority over i_animate in the same cycle); else i_animate -> MOVE, idx=0.
//   MOVE : one slot per cycle, idx 0..NUM_SLOTS-1 (NUM_SLOTS cycles total). Active slot:
//          x < speed -> active<=0; else x<=x-speed. Inactive slot is unchanged. i_animate is ignored here.
//   SPAWN: one cycle. lfsr advances once. speed_cnt++; at SPEED_STEP_FRAMES-1 wrap to 0 and
//          speed<=min(speed+1,MAX_SPEED). If gap!=0: gap--. Else if any slot is free: lowest-index
//          free slot <= {active=1, x=SPAWN_X, is_bird}, gap<=MIN_GAP_FRAMES+(lfsr[7:0]&GAP_MASK).
//          Else (pool full): gap stays 0 and spawn retries next frame. o_frame_done=1 this cycle. -> WAIT.
//   HALT : outputs frozen, o_running=0; i_start -> restart exactly as from IDLE.
//  i_collide during MOVE/SPAWN: the frame update completes; sampled again in WAIT.
//  i_start outside IDLE/HALT: ignored.
//  Frame latency: i_animate -> o_frame_done = NUM_SLOTS+1 cycles. The pipeline is idle long before the next pulse.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; never zero.
//  All outputs are registered. Arithmetic is 10-bit unsigned; the x<speed check prevents underflow.
// CONFIGURATION
//  OBSTACLE_BIRD_EN defined: is_bird = lfsr[8] at spawn.
//  OBSTACLE_BIRD_EN undefined: is_bird is tied 0 and only cacti spawn. The lfsr sequence and gap
//   timing are identical in both builds.
// STRUCTURE
//  dino_pkg: SCREEN_W=640, X_W=10, SPEED_W=4, state enum sched_state_t, slot_t struct {active,is_bird,x}.
//  Sub-module dino_lfsr16 (en, seed load, 16-bit out); the rest is flat in obstacle_scheduler.
// TESTING (NUM_SLOTS=4, GAP_MASK=0 unless noted)
//  1 Reset mid-MOVE (i_rst_n=0 at idx=2) -> all slots inactive, o_speed=2, state IDLE, o_running=0.
//  2 i_start, then 41 i_animate pulses -> slot0 active with x=640 after frame 41;
//    x=638 after frame 42; o_frame_done 5 cycles after each pulse.
//  3 Slot with x=1 at speed 2 -> retired (o_active[k]=0), x held at 1, no wrap to 1023.
//  4 MIN_GAP_FRAMES=0, SPAWN_X=1000 (so nothing retires): frames 1-4 fill slots 0..3; frame 5 spawns nothing and gap stays 0;
//    force slot 2 to retire -> next frame spawns into slot 2 (lowest free).
//  5 SPEED_STEP_FRAMES=3 -> o_speed 2,3,4.. increments every 3rd frame, saturates at 8.
//  6 i_collide and i_animate in the same WAIT cycle -> HALT, slots unchanged, no o_frame_done;
//    i_start -> WAIT with all slots cleared.
//    Undefined OBSTACLE_BIRD_EN -> o_is_bird=0 for 1000 spawns.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and constants for the obstacle pool logic.
package dino_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned X_W      = 10;
    localparam int unsigned SPEED_W  = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StMove,
        StSpawn,
        StHalt
    } sched_state_t;

    typedef struct packed {
        logic           active;
        logic           is_bird;
        logic [X_W-1:0] x;
    } slot_t;

endpackage

// File: rtl/dino_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11. Seed load has priority over advance.
module dino_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    output logic [15:0] o_q
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Shift register with synchronous reset to the seed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lfsr_q <= SEED;
        end else if (i_load) begin
            lfsr_q <= i_seed;
        end else if (i_en) begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

    assign o_q = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Frame-rate controller for the obstacle pool: per-frame scroll, retire and spawn of
// NUM_SLOTS slots, game run state and scroll-speed ramp.
// Build option: define OBSTACLE_BIRD_EN to let spawns pick bird/cactus from lfsr[8];
// otherwise only cacti spawn. LFSR sequence and gap timing are the same in both builds.
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int unsigned NUM_SLOTS         = 4,
    parameter int unsigned SPAWN_X           = SCREEN_W,
    parameter int unsigned INIT_SPEED        = 2,
    parameter int unsigned MAX_SPEED         = 8,
    parameter int unsigned SPEED_STEP_FRAMES = 600,
    parameter int unsigned MIN_GAP_FRAMES    = 40,
    parameter logic [7:0]  GAP_MASK          = 8'h3F
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_animate,
    input  logic                     i_start,
    input  logic                     i_collide,
    output logic [NUM_SLOTS-1:0]     o_active,
    output logic [NUM_SLOTS*X_W-1:0] o_x,
    output logic [NUM_SLOTS-1:0]     o_is_bird,
    output logic [SPEED_W-1:0]       o_speed,
    output logic                     o_running,
    output logic                     o_frame_done
);

    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W = (SPEED_STEP_FRAMES > 2) ? $clog2(SPEED_STEP_FRAMES) : 1;
    localparam int unsigned GAP_W = $clog2(MIN_GAP_FRAMES + 256);

    sched_state_t     state_q, state_d;
    slot_t            slots_q [NUM_SLOTS];
    slot_t            slots_d [NUM_SLOTS];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             frame_done_q;
    logic             running_q;

    logic             restart;
    logic [15:0]      lfsr_q;
    logic             spawn_bird;
    logic [X_W-1:0]   speed_x;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    assign restart = ((state_q == StIdle) || (state_q == StHalt)) && i_start;
    assign speed_x = {{(X_W-SPEED_W){1'b0}}, speed_q};

    dino_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (state_q == StSpawn),
        .i_load  (restart),
        .i_seed  (LFSR_SEED),
        .o_q     (lfsr_q)
    );

`ifdef OBSTACLE_BIRD_EN
    assign spawn_bird = lfsr_q[8];
`else
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_q[15:8];
    assign spawn_bird  = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: collision beats animate in WAIT; MOVE walks every slot once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StHalt: if (i_start) state_d = StWait;
            StWait: begin
                if (i_collide) begin
                    state_d = StHalt;
                end else if (i_animate) begin
                    state_d = StMove;
                end
            end
            StMove:  if (idx_q == IDX_W'(NUM_SLOTS - 1)) state_d = StSpawn;
            StSpawn: state_d = StWait;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: scroll/retire in MOVE, speed ramp and spawn in SPAWN.
    always_comb begin
        slots_d    = slots_q;
        idx_d      = idx_q;
        speed_d    = speed_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        free_found = 1'b0;
        free_idx   = '0;

        // Descending scan so the lowest free index wins.
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!slots_q[k].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end

        if (restart) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slots_d[k] = '0;
            end
            idx_d   = '0;
            speed_d = SPEED_W'(INIT_SPEED);
            cnt_d   = '0;
            gap_d   = GAP_W'(MIN_GAP_FRAMES);
        end else begin
            case (state_q)
                StWait: if (!i_collide && i_animate) idx_d = '0;
                StMove: begin
                    if (slots_q[idx_q].active) begin
                        // Retire instead of subtracting so x never wraps below zero.
                        if (slots_q[idx_q].x < speed_x) begin
                            slots_d[idx_q].active = 1'b0;
                        end else begin
                            slots_d[idx_q].x = slots_q[idx_q].x - speed_x;
                        end
                    end
                    idx_d = (idx_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : idx_q + 1'b1;
                end
                StSpawn: begin
                    if (cnt_q == CNT_W'(SPEED_STEP_FRAMES - 1)) begin
                        cnt_d   = '0;
                        speed_d = (speed_q >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                                   : speed_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end else if (free_found) begin
                        slots_d[free_idx].active  = 1'b1;
                        slots_d[free_idx].is_bird = spawn_bird;
                        slots_d[free_idx].x       = X_W'(SPAWN_X);
                        gap_d = GAP_W'(MIN_GAP_FRAMES) + GAP_W'(lfsr_q[7:0] & GAP_MASK);
                    end
                    // Pool full: gap stays at zero and the spawn retries next frame.
                end
                default: ;
            endcase
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slots_q[k] <= '0;
            end
            idx_q        <= '0;
            speed_q      <= SPEED_W'(INIT_SPEED);
            cnt_q        <= '0;
            gap_q        <= GAP_W'(MIN_GAP_FRAMES);
            frame_done_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slots_q[k] <= slots_d[k];
            end
            idx_q        <= idx_d;
            speed_q      <= speed_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            frame_done_q <= (state_d == StSpawn);
            running_q    <= (state_d == StWait) || (state_d == StMove) ||
                            (state_d == StSpawn);
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot_out
        assign o_active[g]          = slots_q[g].active;
        assign o_is_bird[g]         = slots_q[g].is_bird;
        assign o_x[g*X_W +: X_W]    = slots_q[g].x;
    end

    assign o_speed      = speed_q;
    assign o_running    = running_q;
    assign o_frame_done = frame_done_q;

endmodule
